incline_cond: RTL and testbench

Conditioning stage directly downstream of the inertial interface. Takes the raw 13-bit signed `incline` and its one-cycle `vld` strobe, saturates it to 10 bits, and smooths it with a 1/8 exponential filter. It also derives a hysteretic `steep` flag and a `stale` flag that rises when samples stop arriving. Its outputs feed the assist/PID logic.

---
 rtl/incline_pkg.sv | 19 +
 rtl/incline_cond_if.sv | 24 ++
 rtl/incline_sat.sv | 24 ++
 rtl/incline_cond.sv | 117 +++++++++++
 tb/tb_incline_cond.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/incline_pkg.sv
// Shared types and constants for the incline conditioning path.
// Contents: FSM state encoding, raw/saturated/accumulator widths, saturation limits.
package incline_pkg;

    localparam int unsigned RAW_W  = 13;  // raw signed incline from the inertial interface
    localparam int unsigned SAT_W  = 10;  // saturated / filtered incline
    localparam int unsigned ACC_W  = 14;  // filter accumulator, holds SAT_W value << FRAC_W
    localparam int unsigned FRAC_W = 3;   // filter coefficient is 1/2**FRAC_W

    localparam logic signed [SAT_W-1:0] INC_MAX = 10'sd511;
    localparam logic signed [SAT_W-1:0] INC_MIN = -10'sd512;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        STALE = 2'd2
    } state_e;

endpackage

// File: rtl/incline_cond_if.sv
// Sample/result bundle between the inertial interface side and incline_cond.
// master: drives vld/incline, receives conditioned outputs.
// slave : the conditioning stage.
interface incline_cond_if;
    import incline_pkg::*;

    logic                    vld;           // one-cycle new-sample strobe
    logic signed [RAW_W-1:0] incline;       // raw sample, valid with vld
    logic signed [SAT_W-1:0] filt_incline;  // filtered incline
    logic                    filt_vld;      // pulse on each filt_incline update
    logic                    steep;         // hysteretic steep-grade flag
    logic                    stale;         // no sample within the timeout

    modport master (
        output vld, incline,
        input  filt_incline, filt_vld, steep, stale
    );

    modport slave (
        input  vld, incline,
        output filt_incline, filt_vld, steep, stale
    );

endinterface

// File: rtl/incline_sat.sv
// Combinational signed saturator, RAW_W bits down to SAT_W bits.
// Ports: raw_i  - signed raw incline
//        sat_c_o - clamped to [INC_MIN, INC_MAX] (combinational)
module incline_sat
    import incline_pkg::*;
(
    input  logic signed [RAW_W-1:0] raw_i,
    output logic signed [SAT_W-1:0] sat_c_o
);

    localparam logic signed [RAW_W-1:0] RAW_MAX = RAW_W'(INC_MAX);
    localparam logic signed [RAW_W-1:0] RAW_MIN = RAW_W'(INC_MIN);

    // Clamp out-of-range samples, otherwise keep the low bits unchanged.
    always_comb begin
        sat_c_o = raw_i[SAT_W-1:0];
        if (raw_i > RAW_MAX) begin
            sat_c_o = INC_MAX;
        end else if (raw_i < RAW_MIN) begin
            sat_c_o = INC_MIN;
        end
    end

endmodule

// File: rtl/incline_cond.sv
// Incline conditioning: saturate, 1/8 exponential filter, hysteretic steep flag,
// and a stale flag when samples stop arriving.
// Ports: clk - system clock
//        rst - synchronous active-high reset
//        bus - incline_cond_if.slave (vld/incline in; filt_incline/filt_vld/steep/stale out)
module incline_cond
    import incline_pkg::*;
#(
    parameter int unsigned             TIMEOUT_CYC = 1_000_000,
    parameter logic signed [SAT_W-1:0] STEEP_ON    = 10'sd200,
    parameter logic signed [SAT_W-1:0] STEEP_OFF   = 10'sd150
) (
    input  logic           clk,
    input  logic           rst,
    incline_cond_if.slave  bus
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [SAT_W-1:0] filt_q, filt_d;
    logic                    filt_vld_q, filt_vld_d;
    logic                    steep_q, steep_d;
    logic                    stale_q, stale_d;
    logic signed [SAT_W-1:0] sat_c;
    logic signed [ACC_W-1:0] seed_c;
    logic signed [ACC_W-1:0] step_c;

    incline_sat u_sat (
        .raw_i   (bus.incline),
        .sat_c_o (sat_c)
    );

    // Seed places the sample directly at the filter output; step is acc*(7/8) + sample.
    assign seed_c = ACC_W'(sat_c) <<< FRAC_W;
    assign step_c = acc_q - (acc_q >>> FRAC_W) + ACC_W'(sat_c);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            acc_q      <= '0;
            cnt_q      <= '0;
            filt_q     <= '0;
            filt_vld_q <= 1'b0;
            steep_q    <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            filt_vld_q <= filt_vld_d;
            steep_q    <= steep_d;
            stale_q    <= stale_d;
        end
    end

    // Next-state, filter, timeout and flag logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = '0;
        filt_d     = filt_q;
        filt_vld_d = 1'b0;
        steep_d    = steep_q;
        stale_d    = 1'b0;

        unique case (state_q)
            INIT, STALE: begin
                if (bus.vld) begin
                    acc_d   = seed_c;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                // A sample arriving on the terminal cycle wins over the timeout.
                if (bus.vld) begin
                    acc_d = step_c;
                end else if (cnt_q == CNT_TERM) begin
                    cnt_d   = cnt_q;
                    state_d = STALE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Hysteresis is judged on the value being registered this cycle.
        if (bus.vld) begin
            filt_d     = acc_d[FRAC_W +: SAT_W];
            filt_vld_d = 1'b1;
            if (filt_d >= STEEP_ON) begin
                steep_d = 1'b1;
            end else if (filt_d < STEEP_OFF) begin
                steep_d = 1'b0;
            end
        end

        if (state_d == STALE) begin
            stale_d = 1'b1;
            steep_d = 1'b0;
        end
    end

    assign bus.filt_incline = filt_q;
    assign bus.filt_vld     = filt_vld_q;
    assign bus.steep        = steep_q;
    assign bus.stale        = stale_q;

endmodule

// File: tb/tb_incline_cond.sv
// Directed bench for incline_cond with a 16-cycle timeout.
module tb_incline_cond;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   pulses;

    incline_cond_if bus ();

    incline_cond #(
        .TIMEOUT_CYC (16),
        .STEEP_ON    (10'sd200),
        .STEEP_OFF   (10'sd150)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample at the next edge; outputs are sampled 1 time unit later.
    task automatic send(input int v);
        bus.vld     = 1'b1;
        bus.incline = 13'(v);
        @(posedge clk);
        #1;
        bus.vld     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hyst_exp [15];
        hyst_exp = '{201, 193, 187, 181, 176, 171, 167, 164, 161, 158, 156, 154, 152, 151, 149};
        n_tests = 0;
        n_fail  = 0;
        rst         = 1'b1;
        bus.vld     = 1'b0;
        bus.incline = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_filt",     bus.filt_incline, 0);
        check("rst_filt_vld", bus.filt_vld,     0);
        check("rst_steep",    bus.steep,        0);
        check("rst_stale",    bus.stale,        0);
        rst = 1'b0;

        // Seed
        send(100);
        check("seed_filt",     bus.filt_incline, 100);
        check("seed_filt_vld", bus.filt_vld,     1);
        check("seed_stale",    bus.stale,        0);
        check("seed_steep",    bus.steep,        0);
        idle(1);
        check("seed_pulse_end", bus.filt_vld,     0);
        check("seed_hold",      bus.filt_incline, 100);

        // Saturation
        do_reset();
        send(3000);
        check("sat_hi",       bus.filt_incline, 511);
        check("sat_hi_steep", bus.steep,        1);
        do_reset();
        send(-4000);
        check("sat_lo",       bus.filt_incline, -512);
        check("sat_lo_steep", bus.steep,        0);

        // Filter step and convergence, back-to-back samples
        do_reset();
        send(0);
        check("flt_seed0", bus.filt_incline, 0);
        send(80);
        check("flt_step1", bus.filt_incline, 10);
        send(80);
        check("flt_step2", bus.filt_incline, 18);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            send(80);
            if (bus.filt_vld === 1'b1) pulses++;
        end
        check("flt_converge", bus.filt_incline, 80);
        check("flt_b2b_pulses", pulses, 64);

        // Hysteresis
        do_reset();
        send(210);
        check("hys_seed",       bus.filt_incline, 210);
        check("hys_seed_steep", bus.steep,        1);
        for (int i = 0; i < 15; i++) begin
            send(140);
            check($sformatf("hys_filt_%0d", i),  bus.filt_incline, hyst_exp[i]);
            check($sformatf("hys_steep_%0d", i), bus.steep, (i < 14) ? 1 : 0);
        end
        send(180);
        check("hys_lowhold_filt",  bus.filt_incline, 153);
        check("hys_lowhold_steep", bus.steep,        0);

        // Timeout
        do_reset();
        send(300);
        check("to_seed_steep", bus.steep, 1);
        idle(15);
        check("to_pre_stale", bus.stale, 0);
        check("to_pre_steep", bus.steep, 1);
        idle(1);
        check("to_stale",      bus.stale,        1);
        check("to_steep_off",  bus.steep,        0);
        check("to_filt_hold",  bus.filt_incline, 300);
        idle(5);
        check("to_stale_level", bus.stale,        1);
        check("to_filt_hold2",  bus.filt_incline, 300);
        send(50);
        check("to_reseed_filt",  bus.filt_incline, 50);
        check("to_reseed_stale", bus.stale,        0);
        check("to_reseed_vld",   bus.filt_vld,     1);
        idle(15);
        send(50);
        check("to_term_vld_stale", bus.stale,        0);
        check("to_term_vld_filt",  bus.filt_incline, 50);
        idle(15);
        check("to_term_restart", bus.stale, 0);
        idle(1);
        check("to_term_stale", bus.stale, 1);

        // Reset mid-stream
        send(100);
        check("mrst_seed", bus.filt_incline, 100);
        send(400);
        check("mrst_step", bus.filt_incline, 137);
        check("mrst_step_steep", bus.steep, 0);
        bus.vld     = 1'b1;
        bus.incline = 13'(400);
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_filt",     bus.filt_incline, 0);
        check("mrst_filt_vld", bus.filt_vld,     0);
        check("mrst_steep",    bus.steep,        0);
        check("mrst_stale",    bus.stale,        0);
        send(40);
        check("mrst_reseed",     bus.filt_incline, 40);
        check("mrst_reseed_vld", bus.filt_vld,     1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
